// File: rtl/a5_pkg.sv
// Shared definitions for the A5/1-family cipher engine: FSM encodings, default register geometry, parity/majority helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package a5_pkg;

  // FSM encodings (kept as plain constants for compatibility with older tooling)
  typedef logic [2:0] a5_state_t;
  localparam a5_state_t ST_IDLE   = 3'd0;
  localparam a5_state_t ST_KEY    = 3'd1;
  localparam a5_state_t ST_FRAME  = 3'd2;
  localparam a5_state_t ST_MIX    = 3'd3;
  localparam a5_state_t ST_STREAM = 3'd4;

  // Default register geometry of A5/1
  localparam int          A5_REG1LEN  = 19;
  localparam logic [18:0] A5_MASK1    = 19'h72000;   // taps 18,17,16,13
  localparam int          A5_SYNCBIT1 = 8;
  localparam int          A5_REG2LEN  = 22;
  localparam logic [21:0] A5_MASK2    = 22'h300000;  // taps 21,20
  localparam int          A5_SYNCBIT2 = 10;
  localparam int          A5_REG3LEN  = 23;
  localparam logic [22:0] A5_MASK3    = 23'h700080;  // taps 22,21,20,7
  localparam int          A5_SYNCBIT3 = 10;

  localparam int A5_KEYLEN      = 64;
  localparam int A5_FRAMENUMLEN = 22;
  localparam int A5_MIXCYCLES   = 100;
  localparam int A5_CHUNKLEN    = 114;
  localparam int A5_NUMCHUNKS   = 2;

  // Even parity of a zero-extended vector
  function automatic logic parity32(input logic [31:0] v);
    return ^v;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_lfsr.sv
// One Fibonacci LFSR of the A5 engine with optional step, bit-0 XOR load and synchronous clear.
// Latency: state updates on the clock edge; msb reports the MSB this cycle's step will produce.
// Backpressure: none; the register only moves when step/load_en/clear are asserted.
//
// Ports: clk, rst_n (async active-low), clear (zero the register, wins over step),
//        step (shift in feedback parity), load_en/load_bit (XOR load_bit into bit 0 after the step),
//        msb (post-step MSB, used for the keystream), sync (current clocking bit).
module a5_lfsr
  import a5_pkg::*;
#(
  parameter int             LEN     = 19,
  parameter logic [LEN-1:0] MASK    = '0,
  parameter int             SYNCBIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic step,
  input  logic load_en,
  input  logic load_bit,
  output logic msb,
  output logic sync
);

  logic [LEN-1:0] r;
  logic [LEN-1:0] r_step;
  logic [LEN-1:0] r_next;
  logic           fb;

  always_comb begin
    fb     = parity32(32'(r & MASK));
    r_step = step ? {r[LEN-2:0], fb} : r;
    r_next = r_step;
    r_next[0] = r_step[0] ^ (load_en & load_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clear) begin
      r <= '0;
    end else begin
      r <= r_next;
    end
  end

  // The keystream bit is defined after the step, so expose the stepped MSB;
  // the load only touches bit 0 and cannot affect it.
  assign msb  = r_step[LEN-1];
  assign sync = r[SYNCBIT];

endmodule

// File: rtl/a5_stream_cipher.sv
// A5/1-family cipher engine: start handshake, hardware key/frame setup and mixing, then bit-serial XOR of a bounded keystream.
// Latency: KEYLEN+FRAMENUMLEN+MIXCYCLES cycles from start accept to first in_ready; one cycle from input accept to output.
// Backpressure: single output stage; in_ready drops while out_valid && !out_ready and the LFSRs only step on accepted bits.
//
// Ports: clk, rst_n (async active-low); start/start_ready with key, frame (captured on accept);
//        in_valid/in_ready/in (plaintext bit); out_valid/out_ready/out (ciphertext bit);
//        chunk (chunk index of the next accepted bit); done (one-cycle pulse after the final bit is accepted).
module a5_stream_cipher
  import a5_pkg::*;
#(
  parameter int                 REG1LEN     = A5_REG1LEN,
  parameter logic [REG1LEN-1:0] MASK1       = A5_MASK1,
  parameter int                 SYNCBIT1    = A5_SYNCBIT1,
  parameter int                 REG2LEN     = A5_REG2LEN,
  parameter logic [REG2LEN-1:0] MASK2       = A5_MASK2,
  parameter int                 SYNCBIT2    = A5_SYNCBIT2,
  parameter int                 REG3LEN     = A5_REG3LEN,
  parameter logic [REG3LEN-1:0] MASK3       = A5_MASK3,
  parameter int                 SYNCBIT3    = A5_SYNCBIT3,
  parameter int                 KEYLEN      = A5_KEYLEN,
  parameter int                 FRAMENUMLEN = A5_FRAMENUMLEN,
  parameter int                 MIXCYCLES   = A5_MIXCYCLES,
  parameter int                 CHUNKLEN    = A5_CHUNKLEN,
  parameter int                 NUMCHUNKS   = A5_NUMCHUNKS,
  localparam int                CHW         = (NUMCHUNKS > 1) ? $clog2(NUMCHUNKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   start_ready,
  input  logic [KEYLEN-1:0]      key,
  input  logic [FRAMENUMLEN-1:0] frame,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out,
  output logic [CHW-1:0]         chunk,
  output logic                   done
);

  // One phase counter is shared by KEY, FRAME and MIX
  localparam int SETUP_MAX = (KEYLEN > FRAMENUMLEN)
                             ? ((KEYLEN > MIXCYCLES) ? KEYLEN : MIXCYCLES)
                             : ((FRAMENUMLEN > MIXCYCLES) ? FRAMENUMLEN : MIXCYCLES);
  localparam int CW = $clog2(SETUP_MAX + 1);
  localparam int BW = (CHUNKLEN > 1) ? $clog2(CHUNKLEN) : 1;

  a5_state_t              state;
  logic [KEYLEN-1:0]      key_sr;
  logic [FRAMENUMLEN-1:0] frame_sr;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          bit_cnt;
  logic [CHW-1:0]         chunk_q;
  logic                   out_q;
  logic                   out_valid_q;
  logic                   done_q;

  logic start_acc;
  logic in_acc;
  logic last_bit;
  logic maj;
  logic gamma;
  logic s1, s2, s3;
  logic g1, g2, g3;
  logic step1, step2, step3;
  logic load_en;
  logic load_bit;

  // A pending output bit keeps start_ready low even after the FSM is back in IDLE
  assign start_ready = (state == ST_IDLE) && !out_valid_q;
  assign start_acc   = start && start_ready;
  assign in_ready    = (state == ST_STREAM) && (!out_valid_q || out_ready);
  assign in_acc      = in_valid && in_ready;
  assign maj         = maj3(s1, s2, s3);
  assign gamma       = g1 ^ g2 ^ g3;
  assign last_bit    = in_acc && (bit_cnt == BW'(CHUNKLEN - 1))
                              && (chunk_q == CHW'(NUMCHUNKS - 1));

  always_comb begin
    step1    = 1'b0;
    step2    = 1'b0;
    step3    = 1'b0;
    load_en  = 1'b0;
    load_bit = 1'b0;
    case (state)
      ST_KEY: begin
        step1    = 1'b1;
        step2    = 1'b1;
        step3    = 1'b1;
        load_en  = 1'b1;
        load_bit = key_sr[0];
      end
      ST_FRAME: begin
        step1    = 1'b1;
        step2    = 1'b1;
        step3    = 1'b1;
        load_en  = 1'b1;
        load_bit = frame_sr[0];
      end
      ST_MIX: begin
        step1 = (s1 == maj);
        step2 = (s2 == maj);
        step3 = (s3 == maj);
      end
      ST_STREAM: begin
        // Keystream only advances with an accepted bit, so stalls lose nothing
        step1 = in_acc && (s1 == maj);
        step2 = in_acc && (s2 == maj);
        step3 = in_acc && (s3 == maj);
      end
      default: ;
    endcase
  end

  a5_lfsr #(.LEN(REG1LEN), .MASK(MASK1), .SYNCBIT(SYNCBIT1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .step(step1),
    .load_en(load_en), .load_bit(load_bit), .msb(g1), .sync(s1)
  );

  a5_lfsr #(.LEN(REG2LEN), .MASK(MASK2), .SYNCBIT(SYNCBIT2)) u_r2 (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .step(step2),
    .load_en(load_en), .load_bit(load_bit), .msb(g2), .sync(s2)
  );

  a5_lfsr #(.LEN(REG3LEN), .MASK(MASK3), .SYNCBIT(SYNCBIT3)) u_r3 (
    .clk(clk), .rst_n(rst_n), .clear(start_acc), .step(step3),
    .load_en(load_en), .load_bit(load_bit), .msb(g3), .sync(s3)
  );

  // Control FSM and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_sr   <= '0;
      frame_sr <= '0;
      cnt      <= '0;
      bit_cnt  <= '0;
      chunk_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_bit;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            key_sr   <= key;
            frame_sr <= frame;
            cnt      <= '0;
            bit_cnt  <= '0;
            chunk_q  <= '0;
            state    <= ST_KEY;
          end
        end
        ST_KEY: begin
          // Shift so the bit for the current cycle is always at position 0
          key_sr <= key_sr >> 1;
          if (cnt == CW'(KEYLEN - 1)) begin
            cnt   <= '0;
            state <= ST_FRAME;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FRAME: begin
          frame_sr <= frame_sr >> 1;
          if (cnt == CW'(FRAMENUMLEN - 1)) begin
            cnt   <= '0;
            state <= ST_MIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_MIX: begin
          if (cnt == CW'(MIXCYCLES - 1)) begin
            cnt   <= '0;
            state <= ST_STREAM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STREAM: begin
          if (in_acc) begin
            if (bit_cnt == BW'(CHUNKLEN - 1)) begin
              bit_cnt <= '0;
              if (chunk_q == CHW'(NUMCHUNKS - 1)) begin
                chunk_q <= '0;
                state   <= ST_IDLE;
              end else begin
                chunk_q <= chunk_q + 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output stage: holds its bit until drained, independent of the FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (in_acc) begin
      out_q       <= in ^ gamma;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign chunk     = chunk_q;
  assign done      = done_q;

endmodule

// File: tb/tb_a5_stream_cipher.sv
// Directed bench for a5_stream_cipher: known-answer keystream, setup latency, backpressure, involution, reset abort, busy starts.
// Latency: n/a (testbench).
// Backpressure: out_ready driven constant-high or random per cycle.
module tb_a5_stream_cipher;

  localparam int CHUNK = 114;
  localparam int TOTAL = 228;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_ready;
  logic [63:0] key;
  logic [21:0] frame;
  logic        in_valid;
  logic        in_ready;
  logic        din;
  logic        out_valid;
  logic        out_ready;
  logic        dout;
  logic [0:0]  chunk;
  logic        done;

  int vectors = 0;
  int errors  = 0;

  logic ks [TOTAL];  // reference keystream, first bit of chunk A at index 0
  logic pt [TOTAL];  // plaintext bits actually presented

  a5_stream_cipher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_ready(start_ready),
    .key        (key),
    .frame      (frame),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (din),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (dout),
    .chunk      (chunk),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".start_ready"}, 32'(start_ready), 1);
    chk({tag, ".in_ready"},    32'(in_ready),    0);
    chk({tag, ".out_valid"},   32'(out_valid),   0);
    chk({tag, ".out"},         32'(dout),        0);
    chk({tag, ".chunk"},       32'(chunk),       0);
    chk({tag, ".done"},        32'(done),        0);
  endtask

  // One frame: start, setup, 228 bits. feed=1 presents the reference keystream as plaintext.
  // abort_at >= 0 pulls reset once that many bits have been accepted.
  task automatic run_frame(input bit bp, input bit feed, input bit poke, input int abort_at);
    int cyc;
    int nin;
    int nout;
    int ndone;
    logic exp_b;

    @(negedge clk);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("start_ready_idle", 32'(start_ready), 1);
    @(negedge clk);
    cyc = 0;
    while (1) begin
      start = poke && (cyc == 10 || cyc == 120);
      #1;
      chk("start_ready_busy", 32'(start_ready), 0);
      if (in_ready || cyc >= 400) break;
      @(negedge clk);
      cyc++;
    end
    chk("setup_latency", cyc, 186);

    nin = 0; nout = 0; ndone = 0; cyc = 0;
    while (nout < TOTAL && cyc < 4000) begin
      if (abort_at >= 0 && nin == abort_at) begin
        in_valid = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      in_valid = (nin < TOTAL);
      din      = 1'b0;
      if (nin < TOTAL && feed) din = ks[nin];
      if (nin < TOTAL) pt[nin] = din;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke && (nin == 30);
      #1;
      if (out_valid && !out_ready) chk("in_ready_blocked", 32'(in_ready), 0);
      if (done === 1'b1) ndone++;
      if (out_valid && out_ready) begin
        exp_b = pt[nout] ^ ks[nout];
        chk($sformatf("bit[%0d]", nout), 32'(dout), 32'(exp_b));
        nout++;
      end
      if (in_valid && in_ready) begin
        chk("chunk_idx", 32'(chunk), (nin >= CHUNK) ? 1 : 0);
        nin++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    chk("bits_out", nout, TOTAL);
    chk("done_pulses", ndone, 1);
    #1;
    chk("drained_out_valid", 32'(out_valid), 0);
    chk("start_ready_after", 32'(start_ready), 1);
    chk("chunk_after", 32'(chunk), 0);
  endtask

  initial begin
    logic [119:0] ka;
    logic [119:0] kb;
    ka = 120'h534EAA582FE8151AB6E1855A728C00;
    kb = 120'h24FD35A35D5FB6526D32F906DF1AC0;
    for (int i = 0; i < CHUNK; i++) begin
      ks[i]         = ka[119 - i];
      ks[CHUNK + i] = kb[119 - i];
    end

    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    din       = 1'b0;
    out_ready = 1'b0;
    key       = 64'hEFCDAB8967452312;
    frame     = 22'h134;
    #1;
    check_reset_values("reset_low");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values("reset_released");

    run_frame(1'b0, 1'b0, 1'b0, -1);  // known answer
    run_frame(1'b1, 1'b0, 1'b0, -1);  // random backpressure
    run_frame(1'b0, 1'b1, 1'b0, -1);  // ciphertext in, zeros out
    run_frame(1'b0, 1'b0, 1'b0, 50);  // reset at bit 50 of chunk 0
    run_frame(1'b0, 1'b0, 1'b0, -1);  // clean restart after the abort
    run_frame(1'b0, 1'b0, 1'b1, -1);  // start pulses while busy

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/a5_stream_cipher.md
# a5_stream_cipher

- Parametrised A5/1-family stream cipher engine with three majority-clocked LFSRs.
- A start handshake captures key and frame number. The block then runs the full key setup in hardware: key load, frame load and mixing.
- It then XORs a bounded number of keystream bits onto a bit-serial data stream, using valid/ready flow control on both sides.
- It sits between the burst formatter and the modulator and replaces the free-running single-clock cipher.

## Interface
- REG1LEN, 19, R1 length; MASK1, 19'h72000, R1 feedback taps 18,17,16,13; SYNCBIT1, 8, R1 clocking bit
- REG2LEN, 22, R2 length; MASK2, 22'h300000, taps 21,20; SYNCBIT2, 10
- REG3LEN, 23, R3 length; MASK3, 23'h700080, taps 22,21,20,7; SYNCBIT3, 10
- KEYLEN, 64, key bits; FRAMENUMLEN, 22, frame-number bits; MIXCYCLES, 100, discarded majority cycles
- CHUNKLEN, 114, bits per chunk; NUMCHUNKS, 2, chunks per frame (A→B then B→A)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  request new frame; accepted when start && start_ready
- start_ready  out  1  high only in IDLE
- key  in  KEYLEN  key; bit i loaded on key-load cycle i
- frame  in  FRAMENUMLEN  frame number; bit i loaded on frame-load cycle i
- in_valid / in_ready  in / out  1 / 1  plaintext bit handshake
- in  in  1  plaintext bit
- out_valid / out_ready  out / in  1 / 1  ciphertext bit handshake
- out  out  1  ciphertext bit
- chunk  out  $clog2(NUMCHUNKS)  index of the chunk the next accepted bit belongs to
- done  out  1  one-cycle pulse after the last bit of the last chunk is accepted

## Operation
- FSM states: IDLE, KEY, FRAME, MIX, STREAM.
- IDLE:
  - Registers are zero.
  - On start accept, capture key and frame, clear R1/R2/R3, then go to KEY.
  - start is ignored in every other state.
- KEY (KEYLEN cycles), cycle i:
  - All three registers clock unconditionally.
  - Then key[i] is XORed into bit 0 of each register.
- FRAME (FRAMENUMLEN cycles): same as KEY, using frame[i].
- MIX (MIXCYCLES cycles): majority clocking; output is discarded.
- Register clock step:
  - t = parity(R & MASK).
  - R = {R[LEN-2:0], t}.
- Majority clocking:
  - m = maj(R1[SYNCBIT1], R2[SYNCBIT2], R3[SYNCBIT3]).
  - A register steps only if its sync bit equals m.
- Keystream bit:
  - gamma = R1[MSB] ^ R2[MSB] ^ R3[MSB].
  - gamma is taken after the step in the same cycle.
- STREAM:
  - Each accepted input bit performs one majority step.
  - The output register loads in ^ gamma and sets out_valid.
- A bit counter runs over NUMCHUNKS*CHUNKLEN bits.
  - chunk increments after CHUNKLEN accepted bits.
  - After the final bit: done pulses and the FSM returns to IDLE.
  - In IDLE the registers stay frozen; they are zeroed on the next start accept.
- No LFSR state changes in STREAM without an accepted input bit, so backpressure never loses keystream.

## Timing
- Reset values:
  - state IDLE, R1/R2/R3 = 0, out = 0.
  - out_valid = 0, in_ready = 0, start_ready = 1.
  - chunk = 0, done = 0.
- Setup latency: KEYLEN + FRAMENUMLEN + MIXCYCLES = 186 cycles from the start-accept edge to the first cycle in_ready can be high.
- in_ready = (state==STREAM) && (!out_valid || out_ready).
  - This gives a single output stage and sustains 1 bit/cycle.
- out appears one cycle after in is accepted.
  - out/out_valid hold stable while out_valid && !out_ready.
- If the final input bit is accepted while out_ready is low:
  - done still pulses on that accept.
  - out_valid remains set until drained.
  - start_ready stays low until out_valid clears.
- Reset low mid-operation: everything returns to reset values immediately. A pending output bit is dropped.
- A start held high across IDLE entry is accepted on the first IDLE cycle.

## Structure
- Package a5_pkg: FSM state enum, default lengths/masks/sync positions, and parity/majority functions.
- Sub-module a5_lfsr, instanced ×3:
  - Parameters: LEN, MASK, SYNCBIT.
  - Inputs: step, load_bit, load_en, clear.
  - Outputs: msb, sync bit.
- Top level holds the FSM, counters, majority logic and the output register.

## Test plan
- Known answer, key byte-serial 12 23 45 67 89 AB CD EF (key = 64'hEFCDAB8967452312, LSB-first per byte), frame = 22'h134, in = 0, out_ready = 1:
  - First 114 bits (MSB-first per byte) = 534EAA582FE8151AB6E1855A728C00.
  - Next 114 bits = 24FD35A35D5FB6526D32F906DF1AC0.
  - done pulses once.
- Latency: start accepted at cycle 0 → in_ready first high at cycle 186; start_ready low from cycle 1 until after done.
- Backpressure:
  - out_ready toggled randomly during the known-answer run.
  - Output sequence must be identical to the first scenario.
  - in_ready is never high while out_valid && !out_ready.
- Involution: ciphertext from the first scenario fed back as in with the same key/frame → out equals the original plaintext.
- Reset mid-stream:
  - Assert reset at bit 50 of chunk 0.
  - All outputs return to reset values.
  - A subsequent start reproduces the first scenario from bit 0.
- Start while busy: start pulses during KEY, MIX and STREAM are ignored; results match the first scenario.
